// File: rtl/mem_req_arbiter_if.sv
// Handshake bundle between the fetch port, the data port and the shared SRAM-like bus.
// The master modport is the arbiter's view; slave is the view of the core and bus side.
interface mem_req_arbiter_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic [31:0] inst_rdata;
    logic        inst_data_ok;

    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic [31:0] data_rdata;
    logic        data_data_ok;

    logic        bus_req;
    logic        bus_wr;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok;
    logic [31:0] bus_rdata;
    logic        bus_data_ok;

    modport master (
        input  inst_req, inst_addr,
        output inst_addr_ok, inst_rdata, inst_data_ok,
        input  data_req, data_wr, data_size, data_addr, data_wdata,
        output data_addr_ok, data_rdata, data_data_ok,
        output bus_req, bus_wr, bus_size, bus_addr, bus_wdata,
        input  bus_addr_ok, bus_rdata, bus_data_ok
    );

    modport slave (
        output inst_req, inst_addr,
        input  inst_addr_ok, inst_rdata, inst_data_ok,
        output data_req, data_wr, data_size, data_addr, data_wdata,
        input  data_addr_ok, data_rdata, data_data_ok,
        input  bus_req, bus_wr, bus_size, bus_addr, bus_wdata,
        output bus_addr_ok, bus_rdata, bus_data_ok
    );
endinterface

// File: rtl/mem_req_arbiter.sv
// Arbitrates fetch and data requests onto one shared bus and routes in-order responses
// back through a 1-bit owner FIFO (1 = data).
//
// state  | meaning
// UNLOCK | no request stalled on the bus; owner chosen by priority / round-robin
// LOCK_I | fetch request presented but not yet accepted; fetch holds the bus
// LOCK_D | data request presented but not yet accepted; data holds the bus
module mem_req_arbiter #(
    parameter int OUTSTANDING = 4,
    parameter bit DATA_PRIO   = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    mem_req_arbiter_if.master mif,
    output logic [2:0]  outstanding,
    output logic        protocol_err
);
    localparam int AW = $clog2(OUTSTANDING);
    localparam logic [2:0] CNT_MAX = 3'(OUTSTANDING);

    typedef enum logic [1:0] {UNLOCK, LOCK_I, LOCK_D} state_t;

    state_t                 state, state_nxt;
    logic                   rr_last;
    logic [OUTSTANDING-1:0] owner_fifo;
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic [2:0]             count;
    logic                   owner_data, full, accept, pop, stray, head;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= UNLOCK;
        else         state <= state_nxt;
    end

    always_comb begin
        owner_data       = 1'b0;
        state_nxt        = state;
        full             = (count == CNT_MAX);
        head             = owner_fifo[rd_ptr];
        pop              = mif.bus_data_ok && (count != 3'd0);
        stray            = mif.bus_data_ok && (count == 3'd0);

        case (state)
            LOCK_I: owner_data = 1'b0;
            LOCK_D: owner_data = 1'b1;
            default: begin
                if (DATA_PRIO)
                    owner_data = mif.data_req;
                else if (mif.data_req && mif.inst_req)
                    owner_data = !rr_last;
                else
                    owner_data = mif.data_req;
            end
        endcase

        mif.bus_req   = (owner_data ? mif.data_req : mif.inst_req) && !full && resetn;
        mif.bus_wr    = owner_data ? mif.data_wr    : 1'b0;
        mif.bus_size  = owner_data ? mif.data_size  : 2'd2;
        mif.bus_addr  = owner_data ? mif.data_addr  : mif.inst_addr;
        mif.bus_wdata = owner_data ? mif.data_wdata : 32'd0;
        accept        = mif.bus_req && mif.bus_addr_ok;

        mif.inst_addr_ok = accept && !owner_data;
        mif.data_addr_ok = accept && owner_data;
        mif.inst_data_ok = pop && !head;
        mif.data_data_ok = pop && head;
        mif.inst_rdata   = mif.bus_rdata;
        mif.data_rdata   = mif.bus_rdata;

        // Locking keeps the presented address stable until the bus takes it.
        case (state)
            UNLOCK: begin
                if (mif.bus_req && !mif.bus_addr_ok)
                    state_nxt = owner_data ? LOCK_D : LOCK_I;
            end
            default: begin
                if (accept) state_nxt = UNLOCK;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rr_last      <= 1'b1;
            owner_fifo   <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= 3'd0;
            protocol_err <= 1'b0;
        end else begin
            if (accept) begin
                rr_last            <= owner_data;
                owner_fifo[wr_ptr] <= owner_data;
                wr_ptr             <= wr_ptr + AW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({accept, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
            if (stray)
                protocol_err <= 1'b1;
        end
    end

    assign outstanding = count;
endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed vector bench for mem_req_arbiter: priority/lock/full/stray on a DATA_PRIO=1
// instance, round-robin on a DATA_PRIO=0 instance.
module tb_mem_req_arbiter;
    logic       clk;
    logic       resetn;
    logic [2:0] out_p, out_r;
    logic       perr_p, perr_r;
    int         checks;
    int         failures;

    mem_req_arbiter_if ifp ();
    mem_req_arbiter_if ifr ();

    mem_req_arbiter #(.OUTSTANDING(4), .DATA_PRIO(1'b1)) u_dut (
        .clk(clk), .resetn(resetn), .mif(ifp), .outstanding(out_p), .protocol_err(perr_p)
    );
    mem_req_arbiter #(.OUTSTANDING(4), .DATA_PRIO(1'b0)) u_dut_rr (
        .clk(clk), .resetn(resetn), .mif(ifr), .outstanding(out_r), .protocol_err(perr_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq;
        logic        dwr;
        logic [1:0]  dsize;
        logic [31:0] daddr;
        logic [31:0] dwdata;
        logic        aok;
        logic        dok;
        logic [31:0] rdata;
        logic        e_breq;
        logic        e_bwr;
        logic [1:0]  e_bsize;
        logic [31:0] e_baddr;
        logic [31:0] e_bwdata;
        logic        e_iaok;
        logic        e_daok;
        logic        e_idok;
        logic        e_ddok;
        logic [2:0]  e_out;
        logic        e_perr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(string n, logic ireq, logic [31:0] ia, logic dreq, logic dwr,
                               logic [1:0] ds, logic [31:0] da, logic [31:0] dw, logic aok,
                               logic dok, logic [31:0] rd, logic eb, logic ewr, logic [1:0] es,
                               logic [31:0] eba, logic [31:0] ebw, logic eia, logic eda,
                               logic eid, logic edd, logic [2:0] eo, logic ep);
        vec_t t;
        t.name = n; t.ireq = ireq; t.iaddr = ia; t.dreq = dreq; t.dwr = dwr; t.dsize = ds;
        t.daddr = da; t.dwdata = dw; t.aok = aok; t.dok = dok; t.rdata = rd;
        t.e_breq = eb; t.e_bwr = ewr; t.e_bsize = es; t.e_baddr = eba; t.e_bwdata = ebw;
        t.e_iaok = eia; t.e_daok = eda; t.e_idok = eid; t.e_ddok = edd; t.e_out = eo;
        t.e_perr = ep;
        return t;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(vec_t t);
        ifp.inst_req    = t.ireq;
        ifp.inst_addr   = t.iaddr;
        ifp.data_req    = t.dreq;
        ifp.data_wr     = t.dwr;
        ifp.data_size   = t.dsize;
        ifp.data_addr   = t.daddr;
        ifp.data_wdata  = t.dwdata;
        ifp.bus_addr_ok = t.aok;
        ifp.bus_data_ok = t.dok;
        ifp.bus_rdata   = t.rdata;
    endtask

    task automatic check_vec(vec_t t);
        chk({t.name, ".bus_req"},      32'(ifp.bus_req),      32'(t.e_breq));
        if (t.e_breq) begin
            chk({t.name, ".bus_wr"},    32'(ifp.bus_wr),       32'(t.e_bwr));
            chk({t.name, ".bus_size"},  32'(ifp.bus_size),     32'(t.e_bsize));
            chk({t.name, ".bus_addr"},  ifp.bus_addr,          t.e_baddr);
            chk({t.name, ".bus_wdata"}, ifp.bus_wdata,         t.e_bwdata);
        end
        chk({t.name, ".inst_addr_ok"}, 32'(ifp.inst_addr_ok), 32'(t.e_iaok));
        chk({t.name, ".data_addr_ok"}, 32'(ifp.data_addr_ok), 32'(t.e_daok));
        chk({t.name, ".inst_data_ok"}, 32'(ifp.inst_data_ok), 32'(t.e_idok));
        chk({t.name, ".data_data_ok"}, 32'(ifp.data_data_ok), 32'(t.e_ddok));
        if (t.e_idok) chk({t.name, ".inst_rdata"}, ifp.inst_rdata, t.rdata);
        if (t.e_ddok) chk({t.name, ".data_rdata"}, ifp.data_rdata, t.rdata);
        chk({t.name, ".outstanding"},  32'(out_p),            32'(t.e_out));
        chk({t.name, ".protocol_err"}, 32'(perr_p),           32'(t.e_perr));
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        //            name          ireq iaddr         dreq wr sz da            dw            aok dok rdata
        //                          ebrq ewr esz eaddr         ewdata        iaok daok idok ddok out perr
        vecs.push_back(v("idle",       0, 32'h0,        0, 0, 0, 32'h0,        32'h0,        0, 0, 32'h0,
                                        0, 0, 0, 32'h0,        32'h0,        0, 0, 0, 0, 3'd0, 0));
        vecs.push_back(v("fetch",      1, 32'hBFC00000, 0, 0, 0, 32'h0,        32'h0,        1, 0, 32'h0,
                                        1, 0, 2, 32'hBFC00000, 32'h0,        1, 0, 0, 0, 3'd0, 0));
        vecs.push_back(v("fetch_rsp",  0, 32'h0,        0, 0, 0, 32'h0,        32'h0,        0, 1, 32'h3C080001,
                                        0, 0, 0, 32'h0,        32'h0,        0, 0, 1, 0, 3'd1, 0));
        vecs.push_back(v("prio",       1, 32'hBFC00004, 1, 1, 2, 32'h80001000, 32'hDEADBEEF, 1, 0, 32'h0,
                                        1, 1, 2, 32'h80001000, 32'hDEADBEEF, 0, 1, 0, 0, 3'd0, 0));
        vecs.push_back(v("prio_fetch", 1, 32'hBFC00004, 0, 0, 0, 32'h0,        32'h0,        1, 0, 32'h0,
                                        1, 0, 2, 32'hBFC00004, 32'h0,        1, 0, 0, 0, 3'd1, 0));
        vecs.push_back(v("rsp_d",      0, 32'h0,        0, 0, 0, 32'h0,        32'h0,        0, 1, 32'h11112222,
                                        0, 0, 0, 32'h0,        32'h0,        0, 0, 0, 1, 3'd2, 0));
        vecs.push_back(v("rsp_i",      0, 32'h0,        0, 0, 0, 32'h0,        32'h0,        0, 1, 32'h33334444,
                                        0, 0, 0, 32'h0,        32'h0,        0, 0, 1, 0, 3'd1, 0));
        vecs.push_back(v("lock_c0",    1, 32'hBFC00010, 0, 0, 0, 32'h0,        32'h0,        0, 0, 32'h0,
                                        1, 0, 2, 32'hBFC00010, 32'h0,        0, 0, 0, 0, 3'd0, 0));
        vecs.push_back(v("lock_c1",    1, 32'hBFC00010, 1, 0, 2, 32'h80002000, 32'h0,        0, 0, 32'h0,
                                        1, 0, 2, 32'hBFC00010, 32'h0,        0, 0, 0, 0, 3'd0, 0));
        vecs.push_back(v("lock_c2",    1, 32'hBFC00010, 1, 0, 2, 32'h80002000, 32'h0,        0, 0, 32'h0,
                                        1, 0, 2, 32'hBFC00010, 32'h0,        0, 0, 0, 0, 3'd0, 0));
        vecs.push_back(v("lock_c3",    1, 32'hBFC00010, 1, 0, 2, 32'h80002000, 32'h0,        1, 0, 32'h0,
                                        1, 0, 2, 32'hBFC00010, 32'h0,        1, 0, 0, 0, 3'd0, 0));
        vecs.push_back(v("lock_c4",    0, 32'h0,        1, 0, 2, 32'h80002000, 32'h0,        1, 0, 32'h0,
                                        1, 0, 2, 32'h80002000, 32'h0,        0, 1, 0, 0, 3'd1, 0));
        vecs.push_back(v("drain_i",    0, 32'h0,        0, 0, 0, 32'h0,        32'h0,        0, 1, 32'hAAAA0001,
                                        0, 0, 0, 32'h0,        32'h0,        0, 0, 1, 0, 3'd2, 0));
        vecs.push_back(v("drain_d",    0, 32'h0,        0, 0, 0, 32'h0,        32'h0,        0, 1, 32'hAAAA0002,
                                        0, 0, 0, 32'h0,        32'h0,        0, 0, 0, 1, 3'd1, 0));
        for (int k = 0; k < 4; k++)
            vecs.push_back(v($sformatf("fill%0d", k), 1, 32'h00001000 + 32'(4 * k), 0, 0, 0, 32'h0, 32'h0, 1, 0, 32'h0,
                             1, 0, 2, 32'h00001000 + 32'(4 * k), 32'h0, 1, 0, 0, 0, 3'(k), 0));
        vecs.push_back(v("full_blk",   1, 32'h00001010, 0, 0, 0, 32'h0,        32'h0,        1, 0, 32'h0,
                                        0, 0, 0, 32'h0,        32'h0,        0, 0, 0, 0, 3'd4, 0));
        vecs.push_back(v("full_pop",   1, 32'h00001010, 0, 0, 0, 32'h0,        32'h0,        1, 1, 32'h55555555,
                                        0, 0, 0, 32'h0,        32'h0,        0, 0, 1, 0, 3'd4, 0));
        vecs.push_back(v("pushpop",    1, 32'h00001010, 0, 0, 0, 32'h0,        32'h0,        1, 1, 32'h66666666,
                                        1, 0, 2, 32'h00001010, 32'h0,        1, 0, 1, 0, 3'd3, 0));
        vecs.push_back(v("refill",     1, 32'h00001014, 0, 0, 0, 32'h0,        32'h0,        1, 0, 32'h0,
                                        1, 0, 2, 32'h00001014, 32'h0,        1, 0, 0, 0, 3'd3, 0));
        vecs.push_back(v("full_again", 1, 32'h00001018, 0, 0, 0, 32'h0,        32'h0,        1, 0, 32'h0,
                                        0, 0, 0, 32'h0,        32'h0,        0, 0, 0, 0, 3'd4, 0));
        for (int k = 0; k < 4; k++)
            vecs.push_back(v($sformatf("drain%0d", k), 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, 1, 32'h77000000 + 32'(k),
                             0, 0, 0, 32'h0, 32'h0, 0, 0, 1, 0, 3'(4 - k), 0));
        vecs.push_back(v("stray",      0, 32'h0,        0, 0, 0, 32'h0,        32'h0,        0, 1, 32'h99999999,
                                        0, 0, 0, 32'h0,        32'h0,        0, 0, 0, 0, 3'd0, 0));
        vecs.push_back(v("err_sticky", 0, 32'h0,        0, 0, 0, 32'h0,        32'h0,        0, 0, 32'h0,
                                        0, 0, 0, 32'h0,        32'h0,        0, 0, 0, 0, 3'd0, 1));

        // Reset with a pending fetch: bus_req must stay low.
        resetn = 1'b0;
        drive(vecs[0]);
        ifp.inst_req = 1'b1;
        ifr.inst_req = 1'b0; ifr.inst_addr = 32'h0; ifr.data_req = 1'b0; ifr.data_wr = 1'b0;
        ifr.data_size = 2'd0; ifr.data_addr = 32'h0; ifr.data_wdata = 32'h0;
        ifr.bus_addr_ok = 1'b0; ifr.bus_data_ok = 1'b0; ifr.bus_rdata = 32'h0;
        #3;
        chk("rst.bus_req",      32'(ifp.bus_req), 32'd0);
        chk("rst.inst_addr_ok", 32'(ifp.inst_addr_ok), 32'd0);
        chk("rst.outstanding",  32'(out_p), 32'd0);
        chk("rst.protocol_err", 32'(perr_p), 32'd0);
        ifp.inst_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;

        foreach (vecs[i]) begin
            @(posedge clk);
            #1 drive(vecs[i]);
            #1 check_vec(vecs[i]);
        end

        // Reset asserted while locked to inst with two requests in flight.
        @(posedge clk);
        #1 drive(vecs[0]);
        ifp.inst_req = 1'b1; ifp.inst_addr = 32'h00002000; ifp.bus_addr_ok = 1'b1;
        @(posedge clk);
        #1 ifp.inst_addr = 32'h00002004;
        @(posedge clk);
        #1 ifp.inst_addr = 32'h00002008; ifp.bus_addr_ok = 1'b0;
        @(posedge clk);
        #1 chk("mid.outstanding_pre", 32'(out_p), 32'd2);
        ifp.data_req = 1'b1; ifp.data_addr = 32'h80003000; ifp.data_size = 2'd2;
        ifp.bus_data_ok = 1'b1;
        resetn = 1'b0;
        #1;
        chk("mid.outstanding",  32'(out_p), 32'd0);
        chk("mid.protocol_err", 32'(perr_p), 32'd0);
        chk("mid.bus_req",      32'(ifp.bus_req), 32'd0);
        chk("mid.inst_addr_ok", 32'(ifp.inst_addr_ok), 32'd0);
        chk("mid.inst_data_ok", 32'(ifp.inst_data_ok), 32'd0);
        chk("mid.data_data_ok", 32'(ifp.data_data_ok), 32'd0);
        @(posedge clk);
        #1 resetn = 1'b1; ifp.bus_data_ok = 1'b0;
        #1;
        chk("post.bus_req",  32'(ifp.bus_req), 32'd1);
        chk("post.bus_addr", ifp.bus_addr, 32'h80003000);
        @(posedge clk);
        #1 ifp.bus_addr_ok = 1'b1; ifp.bus_data_ok = 1'b1; ifp.bus_rdata = 32'h12345678;
        #1;
        chk("post.data_addr_ok", 32'(ifp.data_addr_ok), 32'd1);
        chk("post.inst_data_ok", 32'(ifp.inst_data_ok), 32'd0);
        chk("post.data_data_ok", 32'(ifp.data_data_ok), 32'd0);
        @(posedge clk);
        #1 drive(vecs[0]);
        #1;
        chk("post.protocol_err", 32'(perr_p), 32'd1);
        chk("post.outstanding",  32'(out_p), 32'd1);

        // Round-robin instance: both pending every cycle, grants I,D,I,D then full.
        @(posedge clk);
        #1 ifr.inst_req = 1'b1; ifr.inst_addr = 32'h0000A000;
        ifr.data_req = 1'b1; ifr.data_addr = 32'h8000B000; ifr.data_size = 2'd0;
        ifr.bus_addr_ok = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("rr%0d.inst_addr_ok", k), 32'(ifr.inst_addr_ok), (k % 2 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("rr%0d.data_addr_ok", k), 32'(ifr.data_addr_ok), (k % 2 == 1) ? 32'd1 : 32'd0);
            chk($sformatf("rr%0d.bus_addr", k), ifr.bus_addr, (k % 2 == 0) ? 32'h0000A000 : 32'h8000B000);
            @(posedge clk);
            #1;
        end
        #1;
        chk("rr_full.bus_req",     32'(ifr.bus_req), 32'd0);
        chk("rr_full.outstanding", 32'(out_r), 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
